// File: rtl/xbar_pkg.sv
// Shared FSM encoding and width helpers for the break-before-make pin crossbar.
package xbar_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BREAK = 1'b1
  } state_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xbar_bbm_sync_chain.sv
// Reset-to-0 multi-flop synchroniser for one asynchronous source pin.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], din};
  end

  assign dout = ff[STAGES-1];

endmodule

// File: rtl/xbar_bbm.sv
// Registered pin crossbar with shadow/active mapping tables; only remapped outputs
// are released for a break window on commit, untouched outputs keep driving.
module xbar_bbm
  import xbar_pkg::*;
#(
  parameter int INPUT_COUNT  = 16,
  parameter int OUTPUT_COUNT = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int BREAK_CYCLES = 4,
  localparam int SEL_WIDTH   = sel_width(INPUT_COUNT),
  localparam int ADDR_WIDTH  = addr_width(OUTPUT_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INPUT_COUNT-1:0]  sources,
  input  logic                    cfg_we,
  input  logic [ADDR_WIDTH-1:0]   cfg_addr,
  input  logic [SEL_WIDTH-1:0]    cfg_sel,
  input  logic                    cfg_en,
  input  logic                    commit,
  output logic                    busy,
  output logic                    cfg_err,
  output logic [OUTPUT_COUNT-1:0] out
);

  // The window spans BREAK_CYCLES+1 cycles so changed pins see a full release
  // between the last old-mapping drive and the first new-mapping drive.
  localparam int CNT_WIDTH = $clog2(BREAK_CYCLES + 1);

  logic [INPUT_COUNT-1:0]  sync_src;
  logic [SEL_WIDTH-1:0]    shadow_sel  [OUTPUT_COUNT];
  logic [SEL_WIDTH-1:0]    pending_sel [OUTPUT_COUNT];
  logic [SEL_WIDTH-1:0]    active_sel  [OUTPUT_COUNT];
  logic [OUTPUT_COUNT-1:0] shadow_en, pending_en, active_en;
  logic [OUTPUT_COUNT-1:0] brk, changed, out_q, out_oe;
  logic [CNT_WIDTH-1:0]    cnt;
  logic                    wr_ok, load, apply;
  state_t                  state, state_nxt;

  for (genvar g = 0; g < INPUT_COUNT; g++) begin : g_sync
    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (sources[g]),
      .dout (sync_src[g])
    );
  end

  assign wr_ok = cfg_we && (int'(cfg_addr) < OUTPUT_COUNT) && (int'(cfg_sel) < INPUT_COUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUTPUT_COUNT; i++) shadow_sel[i] <= '0;
      shadow_en <= '0;
      cfg_err   <= 1'b0;
    end else begin
      if (wr_ok) begin
        shadow_sel[cfg_addr] <= cfg_sel;
        shadow_en[cfg_addr]  <= cfg_en;
      end
      cfg_err <= cfg_we && !wr_ok;
    end
  end

  always_comb begin
    changed = '0;
    for (int i = 0; i < OUTPUT_COUNT; i++)
      changed[i] = (shadow_sel[i] != active_sel[i]) || (shadow_en[i] != active_en[i]);
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        if (commit && (|changed)) begin
          state_nxt = BREAK;
          load      = 1'b1;
        end
      end
      BREAK: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          apply     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == BREAK);

  // Commit snapshots shadow as it stood before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      brk   <= '0;
      for (int i = 0; i < OUTPUT_COUNT; i++) begin
        pending_sel[i] <= '0;
        active_sel[i]  <= '0;
      end
      pending_en <= '0;
      active_en  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        pending_sel <= shadow_sel;
        pending_en  <= shadow_en;
        brk         <= changed;
        cnt         <= CNT_WIDTH'(BREAK_CYCLES);
      end else if (apply) begin
        active_sel <= pending_sel;
        active_en  <= pending_en;
        brk        <= '0;
      end else if (state == BREAK) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      out_oe <= '0;
    end else begin
      for (int i = 0; i < OUTPUT_COUNT; i++) begin
        out_q[i]  <= sync_src[active_sel[i]];
        out_oe[i] <= active_en[i] & ~brk[i];
      end
    end
  end

  for (genvar o = 0; o < OUTPUT_COUNT; o++) begin : g_pad
    assign out[o] = out_oe[o] ? out_q[o] : 1'bz;
  end

endmodule
